cart_bus_bridge: RTL and testbench
==================================

Name: cart_bus_bridge

Overview:
Upstream neighbour of the cartridge mappers. It samples the slow CPU bus cycle (cpu_clk_in phase, R/W, address, data) in the cart_clk_in domain and converts each cartridge-space access into one clean read or write strobe on the mapper's prg_* port set. It captures the mapper's returned byte when the mapper raises prg_data_en, and it supplies open-bus data on timeout. It sits between the CPU core and any mapperNNN instance.

Parameters:
SYNC_STAGES, 2, flops in the cpu_clk_in synchroniser (min 2)
READ_TIMEOUT, 4, cart_clk cycles to wait for prg_data_en_in before open-bus fallback (1..15)
CART_BASE, 16'h4020, lowest address decoded as cartridge space

Ports:
cart_clk_in  in  1  cart clock; all logic is posedge
reset_in  in  1  asynchronous, active-high reset
cpu_clk_in  in  1  CPU phase clock, asynchronous to cart_clk_in
cpu_rw_in  in  1  1 = read, 0 = write; valid at cpu_clk_in rise
cpu_address_in  in  16  CPU address
cpu_data_in  in  8  CPU write data
cpu_data_out  out  8  read data returned to the CPU; held until the next read completes
cpu_data_valid_out  out  1  one-cycle pulse when cpu_data_out updates
prg_read_out  out  1  read strobe to mapper
prg_write_out  out  1  write strobe to mapper
prg_address_out  out  16  latched address to mapper
prg_data_out  out  8  latched write data to mapper
prg_data_en_in  in  1  mapper data-valid
prg_data_in  in  8  mapper read data

Behaviour:
- Reset (async) values: all outputs 0; state IDLE; sync chain 0; open-bus register 8'h00; timeout counter 0.
- Synchroniser: cpu_clk_in passes through SYNC_STAGES flops. A rise is sync_last=1 with prev=0; a fall is the inverse. Both are one-cycle internal pulses.
- States: IDLE, READ_WAIT, WRITE_HOLD, DONE.
- IDLE, on rise:
  - Latch cpu_address_in, cpu_rw_in and cpu_data_in into prg_address_out and prg_data_out.
  - If address < CART_BASE, stay in IDLE with no strobes. The latched address still updates.
  - Read: go to READ_WAIT. prg_read_out=1 from the next cycle (registered). Latency is SYNC_STAGES+1 cart cycles from the cpu_clk_in edge to the strobe.
  - Write: go to WRITE_HOLD. prg_write_out=1 from the next cycle.
- READ_WAIT: prg_read_out held high; the counter increments each cycle.
  - prg_data_en_in=1: cpu_data_out<=prg_data_in, open-bus<=prg_data_in, one-cycle pulse on cpu_data_valid_out, drop prg_read_out, go to DONE.
  - Counter reaches READ_TIMEOUT with no data_en: cpu_data_out<=open-bus value, valid pulse, go to DONE.
  - Data_en in the same cycle as the timeout: the data wins.
  - prg_read_out is high for at least 1 and at most READ_TIMEOUT cycles.
- WRITE_HOLD: prg_write_out held high until a fall, then deassert and go to DONE.
  - This keeps the write high across the mapper's cpu_frame sampling edge.
  - It guarantees exactly one 0->1 transition of prg_write_out per CPU write. Consecutive CPU writes therefore always show a low gap of at least 1 cycle.
- DONE: all strobes low; return to IDLE on the next fall, or immediately if sync_last is already 0.
- A rise seen while in READ_WAIT or WRITE_HOLD is a missed cycle. Handle it as follows:
  - Abort the current access. A read aborts with the open-bus value and a valid pulse; a write just deasserts.
  - Force strobes low for one cycle.
  - Then process the new access as if from IDLE, with the latched values taken at the new rise.
- prg_read_out and prg_write_out are never high in the same cycle. prg_address_out and prg_data_out are stable whenever either strobe is high.
- Timeout counter width is 4 bits, cleared on every state entry; it saturates and never wraps.
- Mid-operation reset drops the strobes in the same instant (async) and discards the pending access with no valid pulse.

Decomposition:
- Shared package: state enum (IDLE, READ_WAIT, WRITE_HOLD, DONE), CART_BASE default, and the PRG window constants (PRG_RAM_START 16'h6000, PRG_BANK0_START 16'h8000), shared with the mappers.
- One natural sub-module: sync_edge_detect. It holds the SYNC_STAGES flop chain and outputs rise/fall pulses, and is reused for the PPU clock later.

Test Plan:
1. Read at 16'h8000, mapper returns 8'hA5 with data_en 2 cycles after prg_read_out rises -> prg_read_out high exactly 2 cycles, cpu_data_out=8'hA5, one valid pulse, prg_address_out=16'h8000.
2. Read at 16'h6000 with data_en never asserted, after a prior read of 8'h3C -> prg_read_out high 4 cycles, cpu_data_out=8'h3C (open bus), one valid pulse.
3. Five consecutive writes of 8'h80,01,00,01,00 to 16'hA000 -> exactly five prg_write_out rising edges, each spanning its CPU cycle's rise-to-fall, prg_data_out matching each byte, low gap ≥1 cycle between them.
4. Read at 16'h2002 (below CART_BASE) -> no prg_read_out/prg_write_out activity, no valid pulse, state stays IDLE.
5. Assert reset_in while prg_write_out=1 in WRITE_HOLD -> prg_write_out=0 asynchronously, no valid pulse. After release, the next write to 16'hE000 produces a normal single strobe.
6. Second cpu_clk_in rise arrives during READ_WAIT (timeout 15, no data_en) -> abort with open-bus valid pulse, one cycle with strobes low, then prg_read_out for the new address.

Source files
------------

// File: rtl/cart_bus_bridge_pkg.sv
// Types and address-window constants shared by the cartridge bus bridge and the mappers.
package cart_bus_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_READ_WAIT  = 2'd1,
      ST_WRITE_HOLD = 2'd2,
      ST_DONE       = 2'd3
   } bridge_state_t;

   localparam logic [15:0] CART_BASE_DEFAULT = 16'h4020;
   localparam logic [15:0] PRG_RAM_START     = 16'h6000;
   localparam logic [15:0] PRG_BANK0_START   = 16'h8000;
   localparam int          TIMEOUT_W         = 4;

   function automatic logic is_cart_addr(input logic [15:0] addr, input logic [15:0] base);
      return (addr >= base);
   endfunction

endpackage

// File: rtl/cart_bus_bridge_sync.sv
// Multi-flop synchroniser for an asynchronous level, with one-cycle rise/fall pulses.
module sync_edge_detect #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic async_sig,
   output logic sync_level,
   output logic rise_pulse,
   output logic fall_pulse
);

   logic [SYNC_STAGES-1:0] chain_r;
   logic                   prev_r;

   // Shift the async level through the chain and keep one cycle of history.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chain_r <= '0;
         prev_r  <= 1'b0;
      end else begin
         chain_r <= {chain_r[SYNC_STAGES-2:0], async_sig};
         prev_r  <= chain_r[SYNC_STAGES-1];
      end
   end

   assign sync_level = chain_r[SYNC_STAGES-1];
   assign rise_pulse = chain_r[SYNC_STAGES-1] & ~prev_r;
   assign fall_pulse = ~chain_r[SYNC_STAGES-1] & prev_r;

endmodule

// File: rtl/cart_bus_bridge.sv
// Converts sampled CPU bus cycles into single read/write strobes on the mapper prg_* port,
// with open-bus fallback when the mapper does not answer a read in time.
module cart_bus_bridge
   import cart_bus_bridge_pkg::*;
#(
   parameter int          SYNC_STAGES  = 2,
   parameter int          READ_TIMEOUT = 4,
   parameter logic [15:0] CART_BASE    = CART_BASE_DEFAULT
) (
   input  logic        cart_clk_in,
   input  logic        reset_in,
   input  logic        cpu_clk_in,
   input  logic        cpu_rw_in,
   input  logic [15:0] cpu_address_in,
   input  logic [7:0]  cpu_data_in,
   output logic [7:0]  cpu_data_out,
   output logic        cpu_data_valid_out,
   output logic        prg_read_out,
   output logic        prg_write_out,
   output logic [15:0] prg_address_out,
   output logic [7:0]  prg_data_out,
   input  logic        prg_data_en_in,
   input  logic [7:0]  prg_data_in
);

   localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(READ_TIMEOUT - 1);
   localparam logic [TIMEOUT_W-1:0] TO_MAX  = {TIMEOUT_W{1'b1}};

   logic                 sync_last_s;
   logic                 rise_s;
   logic                 fall_s;
   bridge_state_t        state_r;
   logic                 rw_r;
   logic                 pending_r;
   logic [7:0]           open_bus_r;
   logic [TIMEOUT_W-1:0] to_cnt_r;
   logic [15:0]          acc_addr_s;
   logic                 acc_rw_s;
   logic                 timeout_s;

   sync_edge_detect #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_cpu_clk_sync (
      .clk       (cart_clk_in),
      .rst       (reset_in),
      .async_sig (cpu_clk_in),
      .sync_level(sync_last_s),
      .rise_pulse(rise_s),
      .fall_pulse(fall_s)
   );

   // Pick the access to start: a replayed one after an abort, else the live bus.
   always_comb begin
      if (pending_r) begin
         acc_addr_s = prg_address_out;
         acc_rw_s   = rw_r;
      end else begin
         acc_addr_s = cpu_address_in;
         acc_rw_s   = cpu_rw_in;
      end
   end

   assign timeout_s = (to_cnt_r >= TO_LAST);

   // Capture the bus on every CPU clock rise; a rise can only occur while no strobe must stay stable.
   always_ff @(posedge cart_clk_in or posedge reset_in) begin
      if (reset_in) begin
         prg_address_out <= 16'h0000;
         prg_data_out    <= 8'h00;
         rw_r            <= 1'b0;
      end else if (rise_s) begin
         prg_address_out <= cpu_address_in;
         prg_data_out    <= cpu_data_in;
         rw_r            <= cpu_rw_in;
      end else begin
         rw_r            <= rw_r;
      end
   end

   // Bridge state machine with registered strobes and read-data return.
   always_ff @(posedge cart_clk_in or posedge reset_in) begin
      if (reset_in) begin
         state_r            <= ST_IDLE;
         pending_r          <= 1'b0;
         open_bus_r         <= 8'h00;
         to_cnt_r           <= '0;
         cpu_data_out       <= 8'h00;
         cpu_data_valid_out <= 1'b0;
         prg_read_out       <= 1'b0;
         prg_write_out      <= 1'b0;
      end else begin
         cpu_data_valid_out <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (pending_r || rise_s) begin
                  pending_r <= 1'b0;
                  to_cnt_r  <= '0;
                  if (is_cart_addr(acc_addr_s, CART_BASE)) begin
                     if (acc_rw_s) begin
                        state_r      <= ST_READ_WAIT;
                        prg_read_out <= 1'b1;
                     end else begin
                        state_r       <= ST_WRITE_HOLD;
                        prg_write_out <= 1'b1;
                     end
                  end
               end
            end
            ST_READ_WAIT: begin
               if (rise_s) begin
                  // Missed CPU cycle: finish this read now, replay the new access next cycle.
                  prg_read_out       <= 1'b0;
                  cpu_data_valid_out <= 1'b1;
                  cpu_data_out       <= prg_data_en_in ? prg_data_in : open_bus_r;
                  if (prg_data_en_in) begin
                     open_bus_r <= prg_data_in;
                  end
                  pending_r <= 1'b1;
                  to_cnt_r  <= '0;
                  state_r   <= ST_IDLE;
               end else if (prg_data_en_in) begin
                  prg_read_out       <= 1'b0;
                  cpu_data_valid_out <= 1'b1;
                  cpu_data_out       <= prg_data_in;
                  open_bus_r         <= prg_data_in;
                  to_cnt_r           <= '0;
                  state_r            <= ST_DONE;
               end else if (timeout_s) begin
                  prg_read_out       <= 1'b0;
                  cpu_data_valid_out <= 1'b1;
                  cpu_data_out       <= open_bus_r;
                  to_cnt_r           <= '0;
                  state_r            <= ST_DONE;
               end else if (to_cnt_r != TO_MAX) begin
                  to_cnt_r <= to_cnt_r + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
               end
            end
            ST_WRITE_HOLD: begin
               if (rise_s) begin
                  prg_write_out <= 1'b0;
                  pending_r     <= 1'b1;
                  to_cnt_r      <= '0;
                  state_r       <= ST_IDLE;
               end else if (fall_s) begin
                  prg_write_out <= 1'b0;
                  to_cnt_r      <= '0;
                  state_r       <= ST_DONE;
               end
            end
            ST_DONE: begin
               prg_read_out  <= 1'b0;
               prg_write_out <= 1'b0;
               if (!sync_last_s) begin
                  to_cnt_r <= '0;
                  state_r  <= ST_IDLE;
               end
            end
            default: begin
               prg_read_out  <= 1'b0;
               prg_write_out <= 1'b0;
               pending_r     <= 1'b0;
               to_cnt_r      <= '0;
               state_r       <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cart_bus_bridge.sv
// Directed, table-driven bench for cart_bus_bridge (default timeout instance plus a timeout-15 instance).
module tb_cart_bus_bridge;

   localparam int HI = 10;
   localparam int LO = 6;

   logic        cart_clk = 1'b0;
   logic        rst;
   logic        cpu_clk;
   logic        cpu_rw;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        data_en;
   logic [7:0]  map_data;

   logic [7:0]  rdata_a, pdata_a, rdata_b, pdata_b;
   logic        valid_a, rd_a, wr_a, valid_b, rd_b, wr_b;
   logic [15:0] paddr_a, paddr_b;

   int pass_cnt  = 0;
   int total_cnt = 0;

   typedef struct {
      logic [15:0] addr;
      logic        rw;
      logic [7:0]  wdata;
      int          dly;
      logic [7:0]  mdata;
      int          exp_rd;
      int          exp_wr;
      int          exp_valid;
      logic [7:0]  exp_data;
   } vec_t;

   vec_t vecs[14];

   cart_bus_bridge u_dut (
      .cart_clk_in(cart_clk), .reset_in(rst), .cpu_clk_in(cpu_clk), .cpu_rw_in(cpu_rw),
      .cpu_address_in(cpu_addr), .cpu_data_in(cpu_wdata), .cpu_data_out(rdata_a),
      .cpu_data_valid_out(valid_a), .prg_read_out(rd_a), .prg_write_out(wr_a),
      .prg_address_out(paddr_a), .prg_data_out(pdata_a), .prg_data_en_in(data_en),
      .prg_data_in(map_data)
   );

   cart_bus_bridge #(.READ_TIMEOUT(15)) u_dut15 (
      .cart_clk_in(cart_clk), .reset_in(rst), .cpu_clk_in(cpu_clk), .cpu_rw_in(cpu_rw),
      .cpu_address_in(cpu_addr), .cpu_data_in(cpu_wdata), .cpu_data_out(rdata_b),
      .cpu_data_valid_out(valid_b), .prg_read_out(rd_b), .prg_write_out(wr_b),
      .prg_address_out(paddr_b), .prg_data_out(pdata_b), .prg_data_en_in(data_en),
      .prg_data_in(map_data)
   );

   always #5 cart_clk = ~cart_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // One full CPU cycle (HI cart cycles high, LO low) with a mapper answering after v.dly strobe cycles.
   task automatic run_vec(input vec_t v, input string tag);
      int rd_n = 0, wr_n = 0, wr_rise = 0, val_n = 0, bad_addr = 0, bad_data = 0, overlap = 0;
      logic wr_prev = 1'b0;
      @(negedge cart_clk);
      check({tag, "_idle_strobes"}, {30'd0, rd_a, wr_a}, 32'd0);
      cpu_addr  = v.addr;
      cpu_rw    = v.rw;
      cpu_wdata = v.wdata;
      map_data  = v.mdata;
      cpu_clk   = 1'b1;
      for (int i = 0; i < HI + LO; i++) begin
         @(negedge cart_clk);
         data_en = 1'b0;
         if (rd_a) rd_n++;
         if (wr_a) wr_n++;
         if (wr_a && !wr_prev) wr_rise++;
         wr_prev = wr_a;
         if (valid_a) val_n++;
         if (rd_a && wr_a) overlap++;
         if ((rd_a || wr_a) && paddr_a !== v.addr) bad_addr++;
         if (wr_a && pdata_a !== v.wdata) bad_data++;
         if (rd_a && rd_n == v.dly) data_en = 1'b1;
         if (i == HI - 1) cpu_clk = 1'b0;
      end
      check({tag, "_rd_cycles"}, rd_n, v.exp_rd);
      check({tag, "_wr_cycles"}, wr_n, v.exp_wr);
      check({tag, "_wr_rises"}, wr_rise, (v.exp_wr > 0) ? 1 : 0);
      check({tag, "_valid_pulses"}, val_n, v.exp_valid);
      check({tag, "_overlap"}, overlap, 0);
      check({tag, "_addr_stable"}, bad_addr, 0);
      check({tag, "_wdata_stable"}, bad_data, 0);
      check({tag, "_cpu_data"}, rdata_a, v.exp_data);
      check({tag, "_latched_addr"}, paddr_a, v.addr);
   endtask

   initial begin
      bit seen;
      rst = 1'b1; cpu_clk = 1'b0; cpu_rw = 1'b1; cpu_addr = 16'h0000;
      cpu_wdata = 8'h00; data_en = 1'b0; map_data = 8'h00;

      vecs[0]  = '{16'h8000, 1'b1, 8'h00, 2,  8'hA5, 2, 0,  1, 8'hA5};
      vecs[1]  = '{16'h8001, 1'b1, 8'h00, 1,  8'h3C, 1, 0,  1, 8'h3C};
      vecs[2]  = '{16'h6000, 1'b1, 8'h00, -1, 8'hEE, 4, 0,  1, 8'h3C};
      vecs[3]  = '{16'hA000, 1'b0, 8'h80, -1, 8'hEE, 0, HI, 0, 8'h3C};
      vecs[4]  = '{16'hA000, 1'b0, 8'h01, -1, 8'hEE, 0, HI, 0, 8'h3C};
      vecs[5]  = '{16'hA000, 1'b0, 8'h00, -1, 8'hEE, 0, HI, 0, 8'h3C};
      vecs[6]  = '{16'hA000, 1'b0, 8'h01, -1, 8'hEE, 0, HI, 0, 8'h3C};
      vecs[7]  = '{16'hA000, 1'b0, 8'h00, -1, 8'hEE, 0, HI, 0, 8'h3C};
      vecs[8]  = '{16'h2002, 1'b1, 8'h00, -1, 8'hEE, 0, 0,  0, 8'h3C};
      vecs[9]  = '{16'h401F, 1'b1, 8'h00, -1, 8'hEE, 0, 0,  0, 8'h3C};
      vecs[10] = '{16'h4020, 1'b1, 8'h00, 4,  8'h77, 4, 0,  1, 8'h77};
      vecs[11] = '{16'h5000, 1'b1, 8'h00, -1, 8'hEE, 4, 0,  1, 8'h77};
      vecs[12] = '{16'h401F, 1'b0, 8'h11, -1, 8'hEE, 0, 0,  0, 8'h77};
      vecs[13] = '{16'hFFFF, 1'b0, 8'h22, -1, 8'hEE, 0, HI, 0, 8'h77};

      repeat (3) @(negedge cart_clk);
      check("reset_outputs_a", {rdata_a, valid_a, rd_a, wr_a, paddr_a, pdata_a}, 32'd0);
      check("reset_outputs_b", {rdata_b, valid_b, rd_b, wr_b, paddr_b, pdata_b}, 32'd0);
      rst = 1'b0;

      for (int k = 0; k < 14; k++) begin
         run_vec(vecs[k], $sformatf("vec%0d", k));
      end

      // Reset in the middle of a held write.
      @(negedge cart_clk);
      cpu_addr = 16'hE000; cpu_rw = 1'b0; cpu_wdata = 8'h5A; cpu_clk = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 8 && !seen; k++) begin
         @(negedge cart_clk);
         if (wr_a) seen = 1'b1;
      end
      check("rst_wr_seen", seen, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("rst_wr_async_drop", {rd_a, wr_a, valid_a}, 32'd0);
      check("rst_outputs", {rdata_a, paddr_a, pdata_a}, 32'd0);
      cpu_clk = 1'b0;
      repeat (3) @(negedge cart_clk);
      check("rst_no_valid", valid_a, 1'b0);
      rst = 1'b0;
      run_vec('{16'hE000, 1'b0, 8'h33, -1, 8'hEE, 0, HI, 0, 8'h00}, "post_rst");

      // Missed CPU cycle on the timeout-15 instance: abort with open bus, gap, replay.
      @(negedge cart_clk); rst = 1'b1;
      repeat (2) @(negedge cart_clk); rst = 1'b0;
      run_vec('{16'h8000, 1'b1, 8'h00, 1, 8'h5A, 1, 0, 1, 8'h5A}, "prime");
      @(negedge cart_clk);
      cpu_addr = 16'h8001; cpu_rw = 1'b1; map_data = 8'hEE; cpu_clk = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 8 && !seen; k++) begin
         @(negedge cart_clk);
         if (rd_b) seen = 1'b1;
      end
      check("miss_rd_seen", seen, 1'b1);
      repeat (3) @(negedge cart_clk);
      cpu_clk = 1'b0;
      repeat (3) @(negedge cart_clk);
      check("miss_rd_still_high", rd_b, 1'b1);
      cpu_addr = 16'hC000; cpu_clk = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 8 && !seen; k++) begin
         @(negedge cart_clk);
         if (valid_b) begin
            seen = 1'b1;
            check("miss_open_bus", rdata_b, 8'h5A);
            check("miss_gap", {rd_b, wr_b}, 32'd0);
            @(negedge cart_clk);
            check("miss_replay_rd", rd_b, 1'b1);
            check("miss_replay_addr", paddr_b, 16'hC000);
            check("miss_single_valid", valid_b, 1'b0);
         end
      end
      check("miss_valid_seen", seen, 1'b1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
